// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock: FSM state encoding,
// seven-segment patterns (common anode, {abcdefg}, active-low) and key codes.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_ENTRY   = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_LOCKOUT = 3'd4
   } lock_state_e;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   localparam logic [6:0] SEG_D0    = 7'b0000001;
   localparam logic [6:0] SEG_D1    = 7'b1001111;
   localparam logic [6:0] SEG_D2    = 7'b0010010;
   localparam logic [6:0] SEG_D3    = 7'b0000110;
   localparam logic [6:0] SEG_D4    = 7'b1001100;
   localparam logic [6:0] SEG_D5    = 7'b0100100;
   localparam logic [6:0] SEG_D6    = 7'b0100000;
   localparam logic [6:0] SEG_D7    = 7'b0001111;
   localparam logic [6:0] SEG_D8    = 7'b0000000;
   localparam logic [6:0] SEG_D9    = 7'b0000100;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Non-digit codes render as blank so a stray value never lights segments.
   function automatic logic [6:0] code_to_seg(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = SEG_D0;
         4'd1:    seg = SEG_D1;
         4'd2:    seg = SEG_D2;
         4'd3:    seg = SEG_D3;
         4'd4:    seg = SEG_D4;
         4'd5:    seg = SEG_D5;
         4'd6:    seg = SEG_D6;
         4'd7:    seg = SEG_D7;
         4'd8:    seg = SEG_D8;
         4'd9:    seg = SEG_D9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad front end: synchronises key_valid, requires a stable level and code
// for DEB_CYC cycles, and emits a single-cycle press event per touch.
module key_debounce
   import lock_pkg::*;
#(
   parameter logic [15:0] DEB_CYC = 16'd1000
) (
   input  logic       fin,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       press,
   output logic [3:0] press_code
);

   logic [1:0]  sync_q;
   logic [3:0]  code_q;
   logic [15:0] stab_q, stab_d;
   logic        armed_q, armed_d;
   logic        press_q, press_d;
   logic [3:0]  pcode_q, pcode_d;

   // armed_q high: waiting for a stable press; low: waiting for a stable release.
   always_comb begin
      stab_d  = stab_q;
      armed_d = armed_q;
      press_d = 1'b0;
      pcode_d = pcode_q;
      if (armed_q) begin
         if (sync_q[1] && (key_code == code_q)) begin
            if (stab_q == DEB_CYC - 16'd1) begin
               press_d = 1'b1;
               pcode_d = key_code;
               armed_d = 1'b0;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + 16'd1;
            end
         end else begin
            stab_d = '0;
         end
      end else begin
         if (!sync_q[1]) begin
            if (stab_q == DEB_CYC - 16'd1) begin
               armed_d = 1'b1;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + 16'd1;
            end
         end else begin
            stab_d = '0;
         end
      end
   end

   // Synchroniser, code history and debounce state.
   always_ff @(posedge fin or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         code_q  <= '0;
         stab_q  <= '0;
         armed_q <= 1'b1;
         press_q <= 1'b0;
         pcode_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], key_valid};
         code_q  <= key_code;
         stab_q  <= stab_d;
         armed_q <= armed_d;
         press_q <= press_d;
         pcode_q <= pcode_d;
      end
   end

   assign press      = press_q;
   assign press_code = pcode_q;

endmodule

// File: rtl/key_lock_ctrl.sv
// Four-digit keypad lock: digit entry buffer, password check, timed unlock,
// lockout after three consecutive failures, and a multiplexed 4-digit display.
module key_lock_ctrl
   import lock_pkg::*;
#(
   parameter logic [15:0] DEB_CYC  = 16'd1000,
   parameter logic [15:0] SCAN_DIV = 16'd32768,
   parameter logic [15:0] PASSWORD = 16'h1234,
   parameter logic [23:0] OPEN_CYC = 24'd5000000,
   parameter logic [23:0] LOCK_CYC = 24'd15000000
) (
   input  logic       fin,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic [6:0] seg_S,
   output logic [3:0] dig_sel,
   output logic       unlock,
   output logic       alarm
);

   logic        press;
   logic [3:0]  press_code;

   lock_state_e state_q, state_d;
   logic [15:0] buf_q, buf_d;      // {d3,d2,d1,d0}, d0 = most recent digit
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  fail_q, fail_d;
   logic [23:0] tmr_q, tmr_d;

   logic [15:0] scan_q, scan_d;
   logic [1:0]  slot_q, slot_d;
   logic [3:0]  dig_q, dig_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  digit;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .fin        (fin),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .press      (press),
      .press_code (press_code)
   );

   // Lock FSM next state; presses only matter in ENTRY.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      case (state_q)
         ST_ENTRY: begin
            if (press) begin
               if (press_code <= 4'd9) begin
                  buf_d = {buf_q[11:0], press_code};
                  if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
               end else if (press_code == KEY_STAR) begin
                  buf_d = '0;
                  cnt_d = '0;
               end else if (press_code == KEY_HASH) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            tmr_d = '0;
            if ((cnt_q == 3'd4) && (buf_q == PASSWORD)) state_d = ST_OPEN;
            else                                         state_d = ST_FAIL;
         end
         ST_OPEN: begin
            fail_d = '0;
            if (tmr_q == OPEN_CYC - 24'd1) begin
               tmr_d   = '0;
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_ENTRY;
            end else begin
               tmr_d = tmr_q + 24'd1;
            end
         end
         ST_FAIL: begin
            fail_d = fail_q + 2'd1;
            buf_d  = '0;
            cnt_d  = '0;
            tmr_d  = '0;
            if (fail_q == 2'd2) state_d = ST_LOCKOUT;
            else                state_d = ST_ENTRY;
         end
         ST_LOCKOUT: begin
            if (tmr_q == LOCK_CYC - 24'd1) begin
               tmr_d   = '0;
               fail_d  = '0;
               state_d = ST_ENTRY;
            end else begin
               tmr_d = tmr_q + 24'd1;
            end
         end
         default: state_d = ST_ENTRY;
      endcase
   end

   // Lock FSM registers.
   always_ff @(posedge fin or posedge rst) begin
      if (rst) begin
         state_q <= ST_ENTRY;
         buf_q   <= '0;
         cnt_q   <= '0;
         fail_q  <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
         tmr_q   <= tmr_d;
      end
   end

   // Scan timing and per-slot segment selection for the display registers.
   always_comb begin
      scan_d = scan_q + 16'd1;
      slot_d = slot_q;
      if (scan_q == SCAN_DIV - 16'd1) begin
         scan_d = '0;
         slot_d = slot_q + 2'd1;
      end
      case (slot_q)
         2'd0:    digit = buf_q[3:0];
         2'd1:    digit = buf_q[7:4];
         2'd2:    digit = buf_q[11:8];
         default: digit = buf_q[15:12];
      endcase
      dig_d = 4'b0001 << slot_q;
      case (state_q)
         ST_OPEN:    seg_d = SEG_D0;
         ST_LOCKOUT: seg_d = SEG_DASH;
         default:    seg_d = ({1'b0, slot_q} < cnt_q) ? code_to_seg(digit) : SEG_BLANK;
      endcase
   end

   // Display registers: outputs follow the slot counter by one cycle.
   always_ff @(posedge fin or posedge rst) begin
      if (rst) begin
         scan_q <= '0;
         slot_q <= '0;
         dig_q  <= 4'b0001;
         seg_q  <= SEG_BLANK;
      end else begin
         scan_q <= scan_d;
         slot_q <= slot_d;
         dig_q  <= dig_d;
         seg_q  <= seg_d;
      end
   end

   assign seg_S   = seg_q;
   assign dig_sel = dig_q;
   assign unlock  = (state_q == ST_OPEN);
   assign alarm   = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_key_lock_ctrl.sv
// Bench for key_lock_ctrl: stimulus pushes expected unlock/alarm pulses into a
// scoreboard; a negedge monitor pops them and also checks the display.
`timescale 1ns/1ps
module tb_key_lock_ctrl;

   localparam int OPEN_LEN = 16;
   localparam int LOCK_LEN = 32;
   localparam int SCAN_LEN = 8;

   logic       fin = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_code = 4'd0;
   logic       key_valid = 1'b0;
   logic [6:0] seg_S;
   logic [3:0] dig_sel;
   logic       unlock, alarm;

   key_lock_ctrl #(
      .DEB_CYC(16'd4), .SCAN_DIV(16'd8), .PASSWORD(16'h1234),
      .OPEN_CYC(24'd16), .LOCK_CYC(24'd32)
   ) dut (
      .fin(fin), .rst(rst), .key_code(key_code), .key_valid(key_valid),
      .seg_S(seg_S), .dig_sel(dig_sel), .unlock(unlock), .alarm(alarm)
   );

   always #5 fin = ~fin;

   typedef struct { bit is_alarm; int len; } evt_t;

   int   checks = 0;
   int   errors = 0;
   evt_t exp_q[$];
   int   digits[$];     // entered digits, oldest first, at most four kept
   int   fails = 0;
   bit   chk_disp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
         3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
         6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
         9: return 7'b0000100;  default: return 7'b1111111;
      endcase
   endfunction

   // Expected pattern for the slot currently enabled: slot i shows the i-th most recent digit.
   function automatic logic [6:0] exp_seg(input logic [3:0] ds);
      int idx = -1;
      for (int i = 0; i < 4; i++) if (ds == (4'b0001 << i)) idx = i;
      if (idx < 0) return 7'b0101010;
      if (idx < digits.size()) return seg_ref(digits[digits.size() - 1 - idx]);
      return 7'b1111111;
   endfunction

   task automatic end_run(input bit is_alarm, input int len);
      evt_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL evt_unexpected: got pulse alarm=%0d len %0d, expected none", is_alarm, len);
      end else begin
         e = exp_q.pop_front();
         check("evt_kind", 32'(is_alarm), 32'(e.is_alarm));
         check("evt_len", len, e.len);
      end
   endtask

   int         u_len = 0, a_len = 0, since = 0;
   logic [3:0] prev_dig = 4'b0001;
   bit         have_prev = 1'b0;

   // Monitor: pulse lengths against the scoreboard, scan rotation, display contents.
   always @(negedge fin) begin
      if (rst) begin
         u_len = 0; a_len = 0; since = 0; prev_dig = 4'b0001; have_prev = 1'b0;
      end else begin
         if (unlock) begin
            if (u_len > 0) check("open_seg", 32'(seg_S), 32'(7'b0000001));
            u_len++;
         end else if (u_len > 0) begin
            end_run(1'b0, u_len);
            u_len = 0;
         end
         if (alarm) begin
            if (a_len > 0) check("lock_seg", 32'(seg_S), 32'(7'b1111110));
            a_len++;
         end else if (a_len > 0) begin
            end_run(1'b1, a_len);
            a_len = 0;
         end
         if (dig_sel != prev_dig) begin
            check("scan_rot", 32'(dig_sel), 32'({prev_dig[2:0], prev_dig[3]}));
            if (have_prev) check("scan_period", since, SCAN_LEN);
            have_prev = 1'b1;
            since = 1;
            prev_dig = dig_sel;
         end else begin
            since++;
         end
         if (chk_disp) check("disp", 32'(seg_S), 32'(exp_seg(dig_sel)));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge fin);
      #1;
   endtask

   // Reference model of one accepted key, straight from the lock rules.
   task automatic model_key(input int k);
      evt_t e;
      if (k <= 9) begin
         digits.push_back(k);
         if (digits.size() > 4) void'(digits.pop_front());
      end else if (k == 10) begin
         digits.delete();
      end else if (k == 11) begin
         if (digits.size() == 4 && digits[0] == 1 && digits[1] == 2 &&
             digits[2] == 3 && digits[3] == 4) begin
            e.is_alarm = 1'b0; e.len = OPEN_LEN; exp_q.push_back(e);
            fails = 0;
         end else begin
            fails++;
            if (fails == 3) begin
               e.is_alarm = 1'b1; e.len = LOCK_LEN; exp_q.push_back(e);
               fails = 0;
            end
         end
         digits.delete();
      end
   endtask

   task automatic press(input int k, input int hold, input int gap, input bit modeled);
      chk_disp = 1'b0;
      key_code = 4'(k);
      key_valid = 1'b1;
      cycles(hold);
      key_valid = 1'b0;
      if (modeled) model_key(k);
      cycles(gap);
      if (modeled && k != 11) chk_disp = 1'b1;
   endtask

   task automatic key(input int k);
      press(k, $urandom_range(8, 12), $urandom_range(8, 12), 1'b1);
      if (k == 11) begin
         cycles(OPEN_LEN + LOCK_LEN + 10);
         chk_disp = 1'b1;
      end
   endtask

   int wait_n;

   initial begin
      // Reset state
      cycles(3);
      check("rst_unlock", 32'(unlock), 0);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_dig_sel", 32'(dig_sel), 32'(4'b0001));
      check("rst_seg", 32'(seg_S), 32'(7'b1111111));
      rst = 1'b0;
      cycles(2);
      chk_disp = 1'b1;
      cycles(20);

      // Short glitch must not register; a 10-cycle touch registers exactly once.
      key_code = 4'd5; key_valid = 1'b1; cycles(3); key_valid = 1'b0; cycles(16);
      press(5, 10, 10, 1'b1); cycles(16);
      key(10); cycles(10);

      // Correct code opens for the full hold time.
      key(1); key(2); key(3); key(4); key(11); cycles(10);

      // Extra leading digit shifts out; then partial entry cleared with '*'.
      key(9); key(1); key(2); key(3); key(4); cycles(16); key(11);
      key(1); key(2); cycles(16); key(10); cycles(16);

      // Three failures lead to lockout; a touch during lockout is ignored.
      for (int r = 0; r < 3; r++) begin
         key(1); key(2); key(3); key(5);
         if (r < 2) key(11);
         else press(11, 10, 10, 1'b1);
      end
      press(7, 8, 8, 1'b0);
      wait_n = 0;
      while (alarm && wait_n < 80) begin cycles(1); wait_n++; end
      check("lock_end_timeout", 32'(wait_n < 80), 1);
      cycles(5); chk_disp = 1'b1; cycles(20);

      // Reset asserted in the fifth cycle of OPEN aborts at once.
      key(1); key(2); key(3); key(4);
      chk_disp = 1'b0;
      key_code = 4'd11; key_valid = 1'b1;
      wait_n = 0;
      while (!unlock && wait_n < 40) begin @(negedge fin); wait_n++; end
      check("open_rise_timeout", 32'(unlock), 1);
      repeat (4) @(negedge fin);
      key_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("abort_unlock", 32'(unlock), 0);
      check("abort_dig_sel", 32'(dig_sel), 32'(4'b0001));
      check("abort_seg", 32'(seg_S), 32'(7'b1111111));
      digits.delete(); fails = 0;
      cycles(3); rst = 1'b0; cycles(2);
      chk_disp = 1'b1; cycles(20);

      // Randomised entry sessions.
      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) key($urandom_range(0, 9));
            key(1); key(2); key(3); key(4);
         end else begin
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
               int p = $urandom_range(0, 9);
               if (p < 8)       key($urandom_range(0, 9));
               else if (p == 8) key(10);
               else             key($urandom_range(12, 15));
            end
         end
         key(11);
      end

      cycles(60);
      check("evt_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
